// File: rtl/div_unit_pkg.sv
// Shared constants for the EX-stage divider: FSM states, iteration count, ALU control codes.
package div_unit_pkg;

    localparam int unsigned DivIter = 32;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StZero = 2'd2,
        StDone = 2'd3
    } div_state_e;

    // Decoded ALU control codes that upstream uses to form start/signed_div.
    localparam logic [7:0] AluOpDiv  = 8'b0001_1010;
    localparam logic [7:0] AluOpDivu = 8'b0001_1011;

    function automatic logic is_div_op(input logic [7:0] aluop);
        return (aluop == AluOpDiv) || (aluop == AluOpDivu);
    endfunction

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between the EX-stage decode (master) and the divider (slave).
interface div_unit_if #(
    parameter int unsigned DATA_W = 32
);
    logic                  start;
    logic                  signed_div;
    logic [DATA_W-1:0]     opdata1;
    logic [DATA_W-1:0]     opdata2;
    logic                  annul;
    logic [2*DATA_W-1:0]   result;
    logic                  ready;
    logic                  stall;

    modport master (
        output start, signed_div, opdata1, opdata2, annul,
        input  result, ready, stall
    );

    modport slave (
        input  start, signed_div, opdata1, opdata2, annul,
        output result, ready, stall
    );
endinterface

// File: rtl/div_unit_step.sv
// One restoring-division step: trial subtract of the divisor from {rem, dividend msb}.
module div_unit_step #(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_rem,
    input  logic [DATA_W-1:0] i_dvd,
    input  logic [DATA_W-1:0] i_divisor,
    output logic [DATA_W-1:0] o_rem,
    output logic [DATA_W-1:0] o_dvd
);
    logic [DATA_W:0] w_trial;

    assign w_trial = {i_rem, i_dvd[DATA_W-1]} - {1'b0, i_divisor};

    // Dividend shifts out at the top while quotient bits shift in at the bottom.
    always_comb begin
        o_rem = {i_rem[DATA_W-2:0], i_dvd[DATA_W-1]};
        o_dvd = {i_dvd[DATA_W-2:0], 1'b0};
        if (!w_trial[DATA_W]) begin
            o_rem = w_trial[DATA_W-1:0];
            o_dvd = {i_dvd[DATA_W-2:0], 1'b1};
        end
    end
endmodule

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider producing {remainder, quotient} for HI/LO.
// Optional DIV_ZERO_FAST_EN: divisor of zero short-cuts through StZero with a zero result.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned DATA_W = DivIter
) (
    input logic       clk,
    input logic       rst,
    div_unit_if.slave div_if
);
    localparam int unsigned CntW = $clog2(DATA_W);

    div_state_e            r_state;
    logic [CntW-1:0]       r_cnt;
    logic [DATA_W-1:0]     r_rem;
    logic [DATA_W-1:0]     r_dvd;
    logic [DATA_W-1:0]     r_divisor;
    logic                  r_quot_neg;
    logic                  r_rem_neg;
    logic [2*DATA_W-1:0]   r_result;
    logic                  r_ready;

    logic                  w_start_ok;
    logic [DATA_W-1:0]     w_abs_a;
    logic [DATA_W-1:0]     w_abs_b;
    logic [DATA_W-1:0]     w_step_rem;
    logic [DATA_W-1:0]     w_step_dvd;
    logic [DATA_W-1:0]     w_quot_fix;
    logic [DATA_W-1:0]     w_rem_fix;

    assign w_start_ok = div_if.start & ~div_if.annul;
    assign w_abs_a = (div_if.signed_div & div_if.opdata1[DATA_W-1]) ? -div_if.opdata1
                                                                      : div_if.opdata1;
    assign w_abs_b = (div_if.signed_div & div_if.opdata2[DATA_W-1]) ? -div_if.opdata2
                                                                      : div_if.opdata2;

    div_unit_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .i_rem     (r_rem),
        .i_dvd     (r_dvd),
        .i_divisor (r_divisor),
        .o_rem     (w_step_rem),
        .o_dvd     (w_step_dvd)
    );

    // Sign correction applies to the final step's output so it lands with the DONE transition.
    assign w_quot_fix = r_quot_neg ? -w_step_dvd : w_step_dvd;
    assign w_rem_fix  = r_rem_neg  ? -w_step_rem : w_step_rem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_rem      <= '0;
            r_dvd      <= '0;
            r_divisor  <= '0;
            r_quot_neg <= 1'b0;
            r_rem_neg  <= 1'b0;
            r_result   <= '0;
            r_ready    <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            if (div_if.annul) begin
                r_state <= StIdle;
            end else begin
                case (r_state)
                    StIdle: begin
                        if (div_if.start) begin
                            r_dvd      <= w_abs_a;
                            r_divisor  <= w_abs_b;
                            r_quot_neg <= div_if.signed_div &
                                          (div_if.opdata1[DATA_W-1] ^ div_if.opdata2[DATA_W-1]);
                            r_rem_neg  <= div_if.signed_div & div_if.opdata1[DATA_W-1];
                            r_cnt      <= '0;
                            r_rem      <= '0;
`ifdef DIV_ZERO_FAST_EN
                            r_state    <= (div_if.opdata2 == '0) ? StZero : StRun;
`else
                            r_state    <= StRun;
`endif
                        end
                    end
                    StRun: begin
                        r_rem <= w_step_rem;
                        r_dvd <= w_step_dvd;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CntW'(DATA_W - 1)) begin
                            r_result <= {w_rem_fix, w_quot_fix};
                            r_ready  <= 1'b1;
                            r_state  <= StDone;
                        end
                    end
`ifdef DIV_ZERO_FAST_EN
                    StZero: begin
                        r_result <= '0;
                        r_ready  <= 1'b1;
                        r_state  <= StDone;
                    end
`endif
                    StDone:  r_state <= StIdle;
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    assign div_if.stall  = ((r_state == StIdle) & w_start_ok) | (r_state == StRun) |
                           (r_state == StZero);
    assign div_if.result = r_result;
    assign div_if.ready  = r_ready;
endmodule
